// File: rtl/scroll_pkg.sv
// Shared types and constants for the scroll controller.
// Character width, FSM encoding, reset characters, select rotation.
package scroll_pkg;

  localparam int CHAR_W = 2;
  localparam int unsigned TICK_DIV_DEF = 50_000_000;

  typedef logic [CHAR_W-1:0] char_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam char_t RST_U = 2'd0;
  localparam char_t RST_V = 2'd1;
  localparam char_t RST_W = 2'd2;
  localparam char_t RST_X = 2'd3;

  function automatic char_t rot_sel(
    input char_t cur,
    input logic  down
  );
    return down ? cur - char_t'(1) : cur + char_t'(1);
  endfunction

endpackage

// File: rtl/scroll_ctrl_tick_gen.sv
// Rotation prescaler: counts 0..TICK_DIV-1 while run is high.
// tc marks the wrap edge; the count is kept when run drops.
module tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic tc
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tc = run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= tc ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/scroll_ctrl.sv
// Scroll controller: run/hold FSM, rotating select and the
// four character registers feeding the downstream mux.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              dir,
  input  logic              step,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  output logic [CHAR_W-1:0] s,
  output logic [CHAR_W-1:0] u,
  output logic [CHAR_W-1:0] v,
  output logic [CHAR_W-1:0] w,
  output logic [CHAR_W-1:0] x,
  output logic              tick
);

  state_t r_state;
  state_t w_state_nxt;

  logic  r_sync1, r_sync2, r_prev;
  logic  r_vld, r_armed;
  logic  r_tick;
  char_t r_s, r_u, r_v, r_w, r_x;

  logic  w_run, w_tc, w_step_edge, w_adv;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (en)  w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = HOLD;
      HOLD:    if (en)  w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_run = (w_state_nxt == RUN);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .run    (w_run),
    .tc     (w_tc)
  );

  // armed only after a genuine low sample, so a step held
  // through reset release never looks like a new press
  assign w_step_edge = r_sync2 & ~r_prev & r_armed;
  assign w_adv = w_tc | (w_step_edge & ~w_run);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_vld   <= 1'b0;
      r_armed <= 1'b0;
      r_s     <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= step;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_vld   <= 1'b1;
      r_armed <= r_armed | (r_vld & ~r_sync1);
      r_tick  <= w_adv;
      if (w_adv) r_s <= rot_sel(r_s, dir);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_u <= RST_U;
      r_v <= RST_V;
      r_w <= RST_W;
      r_x <= RST_X;
    end else if (wr_en) begin
      unique case (wr_addr)
        2'd0: r_u <= wr_data;
        2'd1: r_v <= wr_data;
        2'd2: r_w <= wr_data;
        2'd3: r_x <= wr_data;
        default: ;
      endcase
    end
  end

  assign s    = r_s;
  assign u    = r_u;
  assign v    = r_v;
  assign w    = r_w;
  assign x    = r_x;
  assign tick = r_tick;

endmodule
